// File: rtl/mem_bus_initiator.sv
// ----------------------------------------------------------------------------
// mem_bus_initiator
//
// Bus-master side of the picoRV32 native memory interface. A command accepted
// on the cmd_* port becomes exactly one mem_valid/mem_ready transaction. The
// result, either read data or a timeout error, is returned on the rsp_* port.
// This lets hardware sequencers program MMIO peripherals without a CPU.
//
// Handshake semantics (cmd_* and rsp_*): a transfer happens on the rising edge
// where valid and ready are both 1. A valid holder keeps its payload stable
// until that edge. cmd_ready depends only on the FSM state.
//
// Ports
//   clk        in   1   system clock, all logic on rising edge
//   reset      in   1   synchronous, active-high reset
//   cmd_valid  in   1   command present
//   cmd_ready  out  1   initiator idle; command taken when cmd_valid&cmd_ready
//   cmd_addr   in   32  byte address
//   cmd_wdata  in   32  write data
//   cmd_wstrb  in   4   byte strobes; 4'b0000 = read
//   rsp_valid  out  1   response present, held until rsp_ready
//   rsp_ready  in   1   consumer takes response
//   rsp_rdata  out  32  read data (0 for writes and errors)
//   rsp_error  out  1   1 = timeout abort
//   mem_valid  out  1   bus request
//   mem_addr   out  32  bus address
//   mem_wdata  out  32  bus write data
//   mem_wstrb  out  4   bus strobes
//   mem_ready  in   1   responder completion
//   mem_rdata  in   32  responder read data
//   dbg_state  out  2   current FSM state (0 idle, 1 bus, 2 response)
// ----------------------------------------------------------------------------
module mem_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_valid;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_wstrb;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_rdata;
    logic             r_rsp_error;

    logic w_accept;
    logic w_done;
    logic w_timeout;
    logic w_rsp_take;

    assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
    // mem_ready only matters while the request is on the bus.
    assign w_done     = (r_state == ST_BUS) && mem_ready;
    // The counter holds the number of BUS edges already spent without
    // mem_ready. When it equals TIMEOUT_CYCLES-1, this edge is the last one
    // allowed, so mem_valid has been high for TIMEOUT_CYCLES cycles. A
    // mem_ready on this same edge still counts as a success.
    assign w_timeout  = (r_state == ST_BUS) && !mem_ready &&
                        (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_rsp_take = (r_state == ST_RESP) && rsp_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (cmd_valid)               w_state_nxt = ST_BUS;
            ST_BUS:  if (mem_ready || w_timeout)  w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready)               w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus and response datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wstrb <= 4'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt       <= '0;
                r_mem_valid <= 1'b1;
                r_mem_addr  <= cmd_addr;
                r_mem_wdata <= cmd_wdata;
                r_mem_wstrb <= cmd_wstrb;
            end else if (w_done) begin
                r_mem_valid <= 1'b0;
                r_mem_wstrb <= 4'h0;
                r_rsp_valid <= 1'b1;
                r_rsp_error <= 1'b0;
                // Only reads return bus data; writes report zero.
                r_rsp_rdata <= (r_mem_wstrb == 4'h0) ? mem_rdata : 32'h0;
            end else if (w_timeout) begin
                r_mem_valid <= 1'b0;
                r_mem_wstrb <= 4'h0;
                r_rsp_valid <= 1'b1;
                r_rsp_error <= 1'b1;
                r_rsp_rdata <= 32'h0;
            end else if (r_state == ST_BUS) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_rsp_take) begin
                r_rsp_valid <= 1'b0;
                r_rsp_error <= 1'b0;
                r_rsp_rdata <= 32'h0;
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_initiator.sv
module tb_mem_bus_initiator;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected response payload {error, rdata} per command
    logic [32:0] exp_q[$];

    mem_bus_initiator #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // Clock: rising edge active, everything sampled/driven at falling edge
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 72'(cmd_ready), 72'(1));
        check({tag, "_mem_valid"}, 72'(mem_valid), 72'(0));
        check({tag, "_mem_addr"},  72'(mem_addr),  72'(0));
        check({tag, "_mem_wdata"}, 72'(mem_wdata), 72'(0));
        check({tag, "_mem_wstrb"}, 72'(mem_wstrb), 72'(0));
        check({tag, "_rsp_valid"}, 72'(rsp_valid), 72'(0));
        check({tag, "_rsp_error"}, 72'(rsp_error), 72'(0));
        check({tag, "_rsp_rdata"}, 72'(rsp_rdata), 72'(0));
    endtask

    // Reference model: a responder that answers after `delay` extra cycles
    // keeps mem_valid up delay+1 cycles, unless that exceeds the timeout window.
    function automatic int model_cycles(input int delay);
        return (delay + 1 <= TIMEOUT) ? delay + 1 : TIMEOUT;
    endfunction

    function automatic logic [32:0] model_rsp(input int delay, input logic [3:0] wstrb,
                                              input logic [31:0] rd);
        if (delay + 1 > TIMEOUT) return {1'b1, 32'h0};
        return {1'b0, (wstrb == 4'h0) ? rd : 32'h0};
    endfunction

    // Full transaction driver. The DUT must be idle on entry (at a falling
    // edge). Optionally pre-drives the next command while the response is
    // held, and pulses a stray mem_ready during the response phase.
    task automatic do_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int delay, input logic [31:0] rd,
                          input int rsp_wait, input bit stray,
                          input bit nxt_valid, input logic [31:0] nxt_addr,
                          input logic [31:0] nxt_wdata, input logic [3:0] nxt_wstrb);
        int cyc;
        logic [32:0] exp;
        check({tag, "_idle_ready"}, 72'(cmd_ready), 72'(1));
        exp_q.push_back(model_rsp(delay, wstrb, rd));
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom();
        cmd_wdata = $urandom();
        cmd_wstrb = 4'($urandom());
        check({tag, "_busy_ready"}, 72'(cmd_ready), 72'(0));
        cyc = 0;
        while (mem_valid === 1'b1 && cyc < 40) begin
            cyc++;
            check({tag, "_bus_fields"}, 72'({mem_addr, mem_wdata, mem_wstrb}),
                  72'({addr, wdata, wstrb}));
            mem_ready = (cyc == delay + 1);
            mem_rdata = mem_ready ? rd : $urandom();
            @(negedge clk);
            mem_ready = 1'b0;
        end
        exp = exp_q.pop_front();
        check({tag, "_valid_cycles"}, 72'(cyc), 72'(model_cycles(delay)));
        check({tag, "_rsp_valid"}, 72'(rsp_valid), 72'(1));
        check({tag, "_rsp_payload"}, 72'({rsp_error, rsp_rdata}), 72'(exp));
        check({tag, "_wstrb_drop"}, 72'(mem_wstrb), 72'(0));
        if (nxt_valid) begin
            cmd_valid = 1'b1;
            cmd_addr  = nxt_addr;
            cmd_wdata = nxt_wdata;
            cmd_wstrb = nxt_wstrb;
        end
        for (int i = 0; i < rsp_wait; i++) begin
            if (stray && i == 0) mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            check({tag, "_rsp_hold"}, 72'({rsp_valid, rsp_error, rsp_rdata}), 72'({1'b1, exp}));
            check({tag, "_hold_quiet"}, 72'({cmd_ready, mem_valid}), 72'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_clear"}, 72'({rsp_valid, rsp_error, rsp_rdata}), 72'(0));
        check({tag, "_ready_back"}, 72'({cmd_ready, mem_valid}), 72'({1'b1, 1'b0}));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] r;
        logic [3:0]  s;
        int          seen;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_reset");

        // Step 1: timer write, responder ready one cycle after valid
        do_txn("write", 32'h0010_001C, 32'h6, 4'hF, 1, 32'hDEAD_BEEF, 0, 1'b0,
               1'b0, 32'h0, 32'h0, 4'h0);

        // Step 2: read returns 3
        do_txn("read", 32'h0010_001C, 32'h0, 4'h0, 1, 32'h0000_0003, 0, 1'b0,
               1'b0, 32'h0, 32'h0, 4'h0);

        // Step 3: no responder -> timeout after TIMEOUT cycles
        do_txn("timeout", 32'h0010_0020, 32'h0, 4'h0, 100, 32'h1234_5678, 0, 1'b0,
               1'b0, 32'h0, 32'h0, 4'h0);

        // Boundaries around the timeout edge
        do_txn("edge_ok", 32'h0010_0024, 32'h0, 4'h0, TIMEOUT - 1, 32'hA5A5_0001, 0, 1'b0,
               1'b0, 32'h0, 32'h0, 4'h0);
        do_txn("edge_late", 32'h0010_0024, 32'h0, 4'h0, TIMEOUT, 32'hA5A5_0002, 0, 1'b0,
               1'b0, 32'h0, 32'h0, 4'h0);
        do_txn("zero_delay", 32'h0010_0028, 32'h0, 4'h0, 0, 32'hCAFE_0000, 0, 1'b0,
               1'b0, 32'h0, 32'h0, 4'h0);

        // Step 4 + 6: held response with stray mem_ready, queued second command
        do_txn("backpress", 32'h0010_0030, 32'h55, 4'h3, 2, 32'h0, 5, 1'b1,
               1'b1, 32'h0010_0034, 32'h0, 4'h0);
        do_txn("queued", 32'h0010_0034, 32'h0, 4'h0, 3, 32'h0BAD_F00D, 0, 1'b0,
               1'b0, 32'h0, 32'h0, 4'h0);

        // Step 6: stray mem_ready while idle
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ready = 1'b0;
        check("stray_idle", 72'({cmd_ready, mem_valid, rsp_valid, rsp_error, rsp_rdata}),
              72'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));

        // Step 5: reset during the third cycle of mem_valid
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0010_001C;
        cmd_wdata = 32'h7;
        cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_mid_valid", 72'(mem_valid), 72'(1));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("mid_reset");
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mem_valid !== 1'b0) seen++;
        end
        check("rst_no_rsp", 72'(seen), 72'(0));
        do_txn("post_reset", 32'h0010_001C, 32'h9, 4'hF, 2, 32'h0, 1, 1'b0,
               1'b0, 32'h0, 32'h0, 4'h0);

        // Randomized transactions
        for (int n = 0; n < 24; n++) begin
            a = $urandom();
            w = $urandom();
            r = $urandom();
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            do_txn("rand", a, w, s, $urandom_range(0, TIMEOUT + 3), r,
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   1'b0, 32'h0, 32'h0, 4'h0);
        end

        check("scoreboard_empty", 72'(exp_q.size()), 72'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
